// File: rtl/otter_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | otter_uart_tx: buffered 8N1/8E1 UART transmitter with valid/ready input   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module otter_uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BW  = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("otter_uart_tx: clocks per bit (DIV) must be at least 2");
    end

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("otter_uart_tx: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            ready_q;

    logic            w_push;
    logic            w_pop;
    logic            w_nonempty;
    logic            w_bit_end;
    logic [7:0]      w_head;

    // READY is a registered copy of "not full", so a full FIFO refuses a push
    // even when the FSM pops on the same edge.
    assign w_push     = valid_i && ready_q;
    assign w_nonempty = (count_q != '0);
    assign w_head     = mem_q[rd_ptr_q];
    assign w_bit_end  = (baud_q == BW'(DIV - 1));

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ready_q <= (count_d != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the line level for the state being entered, keeping TX registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        w_pop   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (w_nonempty) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    par_d   = ^w_head;
                    baud_d  = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        tx_d    = (PARITY_EN != 0) ? par_q : 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (w_nonempty) begin
                        w_pop   = 1'b1;
                        shift_d = w_head;
                        par_d   = ^w_head;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign ready_o = ready_q;
    assign tx_o    = tx_q;
    assign busy_o  = (state_q != S_IDLE) || w_nonempty;
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_otter_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// tb_otter_uart_tx: directed checks of otter_uart_tx at DIV=10, with and
// without parity, using one instance of each configuration.
module tb_otter_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] data_p = 8'h00;
    logic       valid = 1'b0;
    logic       valid_p = 1'b0;
    logic       ready, ready_p, tx, tx_p, busy, busy_p;
    logic [2:0] count, count_p;

    always #5 clk = ~clk;

    otter_uart_tx #(
        .CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4), .PARITY_EN(0)
    ) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid),
        .ready_o(ready), .tx_o(tx), .busy_o(busy), .count_o(count)
    );

    otter_uart_tx #(
        .CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4), .PARITY_EN(1)
    ) u_dut_p (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data_p), .valid_i(valid_p),
        .ready_o(ready_p), .tx_o(tx_p), .busy_o(busy_p), .count_o(count_p)
    );

    typedef struct {
        logic [7:0]  data;
        bit          par;
        logic [10:0] frame;   // bit i = line level of bit slot i (start first)
        int          len;
    } vec_t;

    vec_t vecs [6];

    int n_checks = 0;
    int n_fail   = 0;

    logic cap_tx    [0:699];
    logic cap_busy  [0:699];
    logic cap_ready [0:699];
    int   cap_cnt   [0:699];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Sample m is taken at the falling edge following rising edge N+m.
    task automatic capture(input bit p, input int n);
        for (int m = 0; m < n; m++) begin
            @(negedge clk);
            cap_tx[m]    = p ? tx_p : tx;
            cap_busy[m]  = p ? busy_p : busy;
            cap_ready[m] = p ? ready_p : ready;
            cap_cnt[m]   = p ? int'(count_p) : int'(count);
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || busy_p) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("idle_timeout", 32'(g < 3000), 32'd1);
    endtask

    task automatic send_and_check(input logic [7:0] d, input bit p,
                                  input logic [10:0] frame, input int len,
                                  input string tag);
        wait_idle();
        @(posedge clk); #1;
        if (p) begin data_p = d; valid_p = 1'b1; end
        else   begin data   = d; valid   = 1'b1; end
        @(posedge clk); #1;
        valid = 1'b0; valid_p = 1'b0;
        capture(p, 10 * len + 2);
        check($sformatf("%s_tx_before_pop", tag), 32'(cap_tx[0]), 32'd1);
        check($sformatf("%s_count_after_push", tag), 32'(cap_cnt[0]), 32'd1);
        check($sformatf("%s_ready_after_push", tag), 32'(cap_ready[0]), 32'd1);
        check($sformatf("%s_start_low", tag), 32'(cap_tx[1]), 32'd0);
        check($sformatf("%s_start_last_clk", tag), 32'(cap_tx[10]), 32'd0);
        check($sformatf("%s_bit0_first_clk", tag), 32'(cap_tx[11]), 32'(frame[1]));
        for (int k = 0; k < len; k++) begin
            check($sformatf("%s_bit%0d", tag, k), 32'(cap_tx[6 + 10 * k]), 32'(frame[k]));
        end
        check($sformatf("%s_busy_last", tag), 32'(cap_busy[10 * len]), 32'd1);
        check($sformatf("%s_busy_drop", tag), 32'(cap_busy[10 * len + 1]), 32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            valid   = i[0];
            valid_p = ~i[0];
            data    = 8'h5A;
            data_p  = 8'hC3;
        end
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_tx_p", 32'(tx_p), 32'd1);
        check("rst_count_p", 32'(count_p), 32'd0);
        valid = 1'b0; valid_p = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_busy", 32'(busy | busy_p), 32'd0);
        check("post_rst_tx", 32'(tx), 32'd1);
    endtask

    task automatic test_b2b();
        logic [29:0] s;
        int mx;
        s = {10'b1_0101_0101_0, 10'b1_1111_1111_0, 10'b1_0000_0000_0};
        wait_idle();
        @(posedge clk); #1;
        data = 8'h00; valid = 1'b1;
        fork
            begin
                @(posedge clk); #1; data = 8'hFF;
                @(posedge clk); #1; data = 8'h55;
                @(posedge clk); #1; valid = 1'b0;
            end
            begin
                @(posedge clk);
                capture(1'b0, 302);
            end
        join
        check("b2b_count0", 32'(cap_cnt[0]), 32'd1);
        check("b2b_count1", 32'(cap_cnt[1]), 32'd1);
        check("b2b_count2", 32'(cap_cnt[2]), 32'd2);
        mx = 0;
        for (int m = 0; m < 302; m++) if (cap_cnt[m] > mx) mx = cap_cnt[m];
        check("b2b_count_peak", 32'(mx), 32'd2);
        for (int k = 0; k < 30; k++) begin
            check($sformatf("b2b_bit%0d", k), 32'(cap_tx[6 + 10 * k]), 32'(s[k]));
        end
        check("b2b_stop_end", 32'(cap_tx[100]), 32'd1);
        check("b2b_next_start", 32'(cap_tx[101]), 32'd0);
        check("b2b_busy_last", 32'(cap_busy[300]), 32'd1);
        check("b2b_busy_drop", 32'(cap_busy[301]), 32'd0);
    endtask

    task automatic test_full();
        logic [7:0] b [6];
        int guard;
        bit r;
        bit timeout;
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
        timeout = 1'b0;
        r = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        data = b[0]; valid = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    data  = b[i];
                    guard = 0;
                    do begin
                        @(negedge clk);
                        r = ready;
                        @(posedge clk); #1;
                        guard++;
                    end while (!r && guard < 300);
                    if (!r) timeout = 1'b1;
                end
                valid = 1'b0;
            end
            begin
                @(posedge clk);
                capture(1'b0, 602);
            end
        join
        check("full_push_timeout", 32'(timeout), 32'd0);
        check("full_ready_n3", 32'(cap_ready[3]), 32'd1);
        check("full_count_n4", 32'(cap_cnt[4]), 32'd4);
        check("full_ready_n4", 32'(cap_ready[4]), 32'd0);
        check("full_ready_n100", 32'(cap_ready[100]), 32'd0);
        check("full_count_n101", 32'(cap_cnt[101]), 32'd3);
        check("full_ready_n101", 32'(cap_ready[101]), 32'd1);
        check("full_count_n102", 32'(cap_cnt[102]), 32'd4);
        check("full_ready_n102", 32'(cap_ready[102]), 32'd0);
        for (int j = 0; j < 6; j++) begin
            logic [9:0] f;
            f = {1'b1, b[j], 1'b0};
            for (int k = 0; k < 10; k++) begin
                check($sformatf("full_byte%0d_bit%0d", j, k),
                      32'(cap_tx[6 + 100 * j + 10 * k]), 32'(f[k]));
            end
        end
        check("full_busy_last", 32'(cap_busy[600]), 32'd1);
        check("full_busy_drop", 32'(cap_busy[601]), 32'd0);
    endtask

    task automatic test_midreset();
        wait_idle();
        @(posedge clk); #1;
        data = 8'hC3; valid = 1'b1;
        @(posedge clk); #1;
        data = 8'h81;
        @(posedge clk); #1;
        valid = 1'b0;
        // Now just past edge N+1; move into data bit 3 (edges N+41..N+50).
        repeat (44) @(posedge clk);
        #2;
        check("midrst_pre_tx", 32'(tx), 32'd0);
        check("midrst_pre_count", 32'(count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_and_check(8'h3C, 1'b0, 11'b0_1_0011_1100_0, 10, "after_rst_3C");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, par: 1'b0, frame: 11'b0_1_1010_0101_0, len: 10};
        vecs[1] = '{data: 8'h3C, par: 1'b0, frame: 11'b0_1_0011_1100_0, len: 10};
        vecs[2] = '{data: 8'h07, par: 1'b1, frame: 11'b1_1_0000_0111_0, len: 11};
        vecs[3] = '{data: 8'h03, par: 1'b1, frame: 11'b1_0_0000_0011_0, len: 11};
        vecs[4] = '{data: 8'h00, par: 1'b0, frame: 11'b0_1_0000_0000_0, len: 10};
        vecs[5] = '{data: 8'hFF, par: 1'b1, frame: 11'b1_0_1111_1111_0, len: 11};

        test_reset();
        for (int v = 0; v < 6; v++) begin
            send_and_check(vecs[v].data, vecs[v].par, vecs[v].frame, vecs[v].len,
                           $sformatf("vec%0d_%02h", v, vecs[v].data));
        end
        test_b2b();
        test_full();
        test_midreset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
